// File: rtl/score_display.sv
// Saturating four-digit BCD score counter with a multiplexed common-anode display.
// Each digit is shown for DIV clocks. Blank leading zeros are suppressed.
module score_display #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    input  logic        hold,
    output logic [15:0] score,
    output logic [3:0]  AN,
    output logic [6:0]  CA
);

    localparam int RW = $clog2(DIV);

    logic          inc_d_q, inc_d_d;
    logic [15:0]   score_q, score_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    ca_q, ca_d;

    logic          inc_event;
    logic          carry;
    logic          rcnt_wrap;
    logic          blank;
    logic [3:0]    digit;
    logic [3:0]    nib;

    always_comb begin
        inc_d_d   = inc;
        inc_event = inc & ~inc_d_q & ~hold;
        score_d   = score_q;
        carry     = 1'b0;
        nib       = 4'd0;
        if (inc_event && score_q != 16'h9999) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                nib = score_q[i*4 +: 4];
                if (carry) begin
                    if (nib == 4'd9) begin
                        score_d[i*4 +: 4] = 4'd0;
                    end else begin
                        score_d[i*4 +: 4] = nib + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end

        rcnt_wrap = (rcnt_q == RW'(DIV - 1));
        rcnt_d    = rcnt_wrap ? '0 : rcnt_q + 1'b1;
        sel_d     = rcnt_wrap ? sel_q + 2'd1 : sel_q;

        // A slot is blank when its digit and every digit above it is zero.
        case (sel_q)
            2'd0: begin digit = score_q[3:0];   blank = 1'b0;                    end
            2'd1: begin digit = score_q[7:4];   blank = (score_q[15:4] == 12'd0); end
            2'd2: begin digit = score_q[11:8];  blank = (score_q[15:8] == 8'd0);  end
            default: begin digit = score_q[15:12]; blank = (score_q[15:12] == 4'd0); end
        endcase

        case (digit)
            4'd0: ca_d = 7'b1000000;
            4'd1: ca_d = 7'b1111001;
            4'd2: ca_d = 7'b0100100;
            4'd3: ca_d = 7'b0110000;
            4'd4: ca_d = 7'b0011001;
            4'd5: ca_d = 7'b0010010;
            4'd6: ca_d = 7'b0000010;
            4'd7: ca_d = 7'b1111000;
            4'd8: ca_d = 7'b0000000;
            4'd9: ca_d = 7'b0010000;
            default: ca_d = 7'b1111111;
        endcase

        an_d = ~(4'b0001 << sel_q);
        if (blank) begin
            an_d = 4'b1111;
            ca_d = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            inc_d_q <= 1'b0;
            score_q <= 16'h0000;
            rcnt_q  <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1110;
            ca_q    <= 7'b1000000;
        end else begin
            inc_d_q <= inc_d_d;
            score_q <= score_d;
            rcnt_q  <= rcnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

    assign score = score_q;
    assign AN    = an_q;
    assign CA    = ca_q;

endmodule
